// File: rtl/mac_unit_bitserial_acc.sv
// Bit-serial dot-product MAC. Consumes one weight magnitude bit-column per handshake, MSB first,
// and accumulates the shifted lane sum into a full-precision signed result.
module mac_unit_bitserial_acc #(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LENGTH = 16,
  parameter int MAX_WBITS  = 8,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic                               load_accum,
  input  logic [ACC_WIDTH-1:0]               accum_prev,
  input  logic [$clog2(MAX_WBITS+1)-1:0]     w_prec,
  input  logic [VEC_LENGTH*DATA_WIDTH-1:0]   act_in,
  input  logic [VEC_LENGTH-1:0]              sign,
  input  logic                               col_valid,
  input  logic [VEC_LENGTH-1:0]              w_bit,
  output logic                               col_ready,
  output logic [$clog2(MAX_WBITS)-1:0]       col_idx,
  output logic                               busy,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [ACC_WIDTH-1:0]               result
);

  localparam int WP_W   = $clog2(MAX_WBITS + 1);
  localparam int CI_W   = $clog2(MAX_WBITS);
  localparam int LANE_W = DATA_WIDTH + 1;
  localparam int SUM_W  = LANE_W + $clog2(VEC_LENGTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // One extra bit so that negating the most negative activation stays exact.
  function automatic logic signed [LANE_W-1:0] lane_val(input logic [DATA_WIDTH-1:0] a,
                                                        input logic b, input logic s);
    logic signed [LANE_W-1:0] x;
    x = {a[DATA_WIDTH-1], a};
    if (!b) return '0;
    return s ? -x : x;
  endfunction

  // Pairwise reduction; each level may grow by one bit, SUM_W covers the full tree.
  function automatic logic signed [SUM_W-1:0] tree_sum(input logic [VEC_LENGTH*LANE_W-1:0] lanes);
    logic signed [SUM_W-1:0] node [VEC_LENGTH];
    for (int j = 0; j < VEC_LENGTH; j++)
      node[j] = SUM_W'($signed(lanes[j*LANE_W +: LANE_W]));
    for (int n = VEC_LENGTH; n > 1; n = n / 2)
      for (int i = 0; i < n / 2; i++)
        node[i] = node[2*i] + node[2*i+1];
    return node[0];
  endfunction

  state_t                          state_q, state_d;
  logic signed [ACC_WIDTH-1:0]     acc_q, acc_d;
  logic [VEC_LENGTH*DATA_WIDTH-1:0] act_q, act_d;
  logic [VEC_LENGTH-1:0]           sign_q, sign_d;
  logic [CI_W-1:0]                 col_idx_q, col_idx_d;
  logic                            col_ready_q, col_ready_d;
  logic                            out_valid_q, out_valid_d;
  logic                            busy_q, busy_d;

  logic [VEC_LENGTH*LANE_W-1:0]    lanes;
  logic signed [SUM_W-1:0]         psum;
  logic signed [ACC_WIDTH-1:0]     psum_ext;
  logic signed [ACC_WIDTH-1:0]     col_term;
  logic [WP_W-1:0]                 p_eff;

  always_comb begin
    lanes = '0;
    for (int j = 0; j < VEC_LENGTH; j++)
      lanes[j*LANE_W +: LANE_W] = lane_val(act_q[j*DATA_WIDTH +: DATA_WIDTH], w_bit[j], sign_q[j]);
  end

  assign psum     = tree_sum(lanes);
  assign psum_ext = ACC_WIDTH'(psum);
  assign col_term = psum_ext <<< col_idx_q;
  assign p_eff    = (w_prec > WP_W'(MAX_WBITS)) ? WP_W'(MAX_WBITS) : w_prec;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    act_d       = act_q;
    sign_d      = sign_q;
    col_idx_d   = col_idx_q;
    col_ready_d = col_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          act_d  = act_in;
          sign_d = sign;
          acc_d  = load_accum ? accum_prev : '0;
          busy_d = 1'b1;
          if (p_eff == '0) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            col_idx_d   = '0;
          end else begin
            state_d     = RUN;
            col_ready_d = 1'b1;
            col_idx_d   = CI_W'(p_eff - WP_W'(1));
          end
        end
      end
      RUN: begin
        if (col_valid) begin
          acc_d = acc_q + col_term;
          if (col_idx_q == '0) begin
            state_d     = DONE;
            col_ready_d = 1'b0;
            out_valid_d = 1'b1;
          end else begin
            col_idx_d = col_idx_q - CI_W'(1);
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        col_ready_d = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      act_q       <= '0;
      sign_q      <= '0;
      col_idx_q   <= '0;
      col_ready_q <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      act_q       <= act_d;
      sign_q      <= sign_d;
      col_idx_q   <= col_idx_d;
      col_ready_q <= col_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign col_ready = col_ready_q;
  assign col_idx   = col_idx_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign result    = acc_q;

endmodule

// File: tb/tb_mac_unit_bitserial_acc.sv
// Scoreboard bench for the bit-serial accumulating MAC: expected dot products are queued at
// start and compared whenever a result is handed off.
module tb_mac_unit_bitserial_acc;
  localparam int DW = 8;
  localparam int VL = 16;
  localparam int MW = 8;
  localparam int AW = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              load_accum;
  logic [AW-1:0]     accum_prev;
  logic [3:0]        w_prec;
  logic [VL*DW-1:0]  act_in;
  logic [VL-1:0]     sign;
  logic              col_valid;
  logic [VL-1:0]     w_bit;
  logic              col_ready;
  logic [2:0]        col_idx;
  logic              busy;
  logic              out_valid;
  logic              out_ready;
  logic [AW-1:0]     result;

  mac_unit_bitserial_acc #(
    .DATA_WIDTH(DW), .VEC_LENGTH(VL), .MAX_WBITS(MW), .ACC_WIDTH(AW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .load_accum(load_accum),
    .accum_prev(accum_prev), .w_prec(w_prec), .act_in(act_in), .sign(sign),
    .col_valid(col_valid), .w_bit(w_bit), .col_ready(col_ready), .col_idx(col_idx),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  always #5 clk = ~clk;

  int            n_chk  = 0;
  int            n_pass = 0;
  logic [AW-1:0] exp_q[$];
  int            act_v[VL];
  int            w_v[VL];
  logic [VL-1:0] sgn_v;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Direct dot product over the effective precision, independent of column order.
  function automatic logic [AW-1:0] model(input int prec, input bit ld, input int seed);
    longint acc;
    int     p;
    p   = (prec > MW) ? MW : prec;
    acc = ld ? longint'(seed) : 0;
    for (int j = 0; j < VL; j++)
      acc += longint'(act_v[j]) * (sgn_v[j] ? -1 : 1) * longint'(w_v[j] & ((1 << p) - 1));
    return acc[AW-1:0];
  endfunction

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("result_unexpected", 64'(exp_q.size()), 64'd1);
      else                   chk("result", result, exp_q.pop_front());
    end
  end

  task automatic run_op(input int prec, input bit ld, input int seed, input bit gaps,
                        input int hold, input bit score, input int abort_after,
                        input logic [AW-1:0] e);
    int p;
    p = (prec > MW) ? MW : prec;
    @(posedge clk); #1;
    start      = 1'b1;
    load_accum = ld;
    accum_prev = AW'(seed);
    w_prec     = 4'(prec);
    sign       = sgn_v;
    for (int j = 0; j < VL; j++) act_in[j*DW +: DW] = DW'(act_v[j]);
    if (score) exp_q.push_back(e);
    @(posedge clk); #1;
    start      = 1'b0;
    act_in     = ~act_in;
    sign       = ~sign;
    load_accum = ~ld;
    accum_prev = ~accum_prev;
    w_prec     = ~w_prec;
    chk("busy_after_start", busy, 1);
    for (int c = p - 1; c >= 0; c--) begin
      if (gaps) begin
        for (int g = 0; g < 2; g++) begin
          col_valid = 1'b0;
          w_bit     = '1;
          start     = (g == 0);
          @(posedge clk); #1;
          chk("stall_idx", col_idx, c);
          chk("stall_ready", col_ready, 1);
        end
        start = 1'b0;
      end
      chk("col_ready", col_ready, 1);
      chk("col_idx", col_idx, c);
      col_valid = 1'b1;
      for (int j = 0; j < VL; j++) w_bit[j] = 1'((w_v[j] >> c) & 1);
      @(posedge clk); #1;
      col_valid = 1'b0;
      w_bit     = '0;
      if (p - c == abort_after) begin
        #2 reset = 1'b1;
        #1;
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_result", result, 0);
        chk("abort_ready", col_ready, 0);
        chk("abort_idx", col_idx, 0);
        #1 reset = 1'b0;
        return;
      end
    end
    chk("out_valid", out_valid, 1);
    chk("done_ready", col_ready, 0);
    for (int h = 0; h < hold; h++) begin
      start = (h == 1);
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_result", result, e);
      chk("hold_ready", col_ready, 0);
    end
    start     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    start     = 1'b0;
    chk("idle_busy", busy, 0);
    chk("idle_valid", out_valid, 0);
  endtask

  task automatic setup_uniform(input int a, input int w, input bit s);
    for (int j = 0; j < VL; j++) begin
      act_v[j] = a;
      w_v[j]   = w;
      sgn_v[j] = s;
    end
  endtask

  task automatic setup_lane0;
    setup_uniform(0, 0, 1'b0);
    act_v[0] = 5;
    w_v[0]   = 5;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; load_accum = 1'b0; accum_prev = '0; w_prec = '0;
    act_in = '0; sign = '0; col_valid = 1'b0; w_bit = '0; out_ready = 1'b0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", col_ready, 0);
    chk("rst_idx", col_idx, 0);
    chk("rst_result", result, 0);
    #1 reset = 1'b0;

    setup_uniform(1, 255, 1'b0);
    run_op(8, 1'b0, 0, 1'b0, 0, 1'b1, 0, 32'd4080);

    setup_uniform(-128, 1, 1'b1);
    run_op(1, 1'b0, 0, 1'b0, 0, 1'b1, 0, 32'd2048);

    setup_lane0();
    run_op(3, 1'b1, -100, 1'b0, 0, 1'b1, 0, AW'(-75));

    setup_uniform(1, 255, 1'b0);
    run_op(8, 1'b0, 0, 1'b1, 5, 1'b1, 0, 32'd4080);

    setup_uniform(1, 255, 1'b0);
    run_op(8, 1'b0, 0, 1'b0, 0, 1'b0, 3, '0);
    setup_lane0();
    run_op(3, 1'b1, -100, 1'b0, 0, 1'b1, 0, AW'(-75));

    setup_uniform(7, 3, 1'b0);
    run_op(0, 1'b1, 1234, 1'b0, 2, 1'b1, 0, 32'd1234);

    for (int j = 0; j < VL; j++) begin
      act_v[j] = int'($urandom_range(0, 255)) - 128;
      w_v[j]   = int'($urandom_range(0, 255));
      sgn_v[j] = 1'($urandom_range(0, 1));
    end
    run_op(15, 1'b0, 0, 1'b0, 0, 1'b1, 0, model(15, 1'b0, 0));

    for (int k = 0; k < 4; k++) begin
      int prec;
      int seed;
      for (int j = 0; j < VL; j++) begin
        act_v[j] = int'($urandom_range(0, 255)) - 128;
        w_v[j]   = int'($urandom_range(0, 255));
        sgn_v[j] = 1'($urandom_range(0, 1));
      end
      prec = int'($urandom_range(1, 8));
      seed = int'($urandom_range(0, 20000)) - 10000;
      run_op(prec, 1'(k & 1), seed, 1'(k >> 1), k, 1'b1, 0, model(prec, 1'(k & 1), seed));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
